// File: rtl/arty_s7_pkg.sv
// Shared constants and helper functions for the Arty S7 input conditioning slice.
package arty_s7_pkg;

    localparam int unsigned N_SW  = 4;
    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_CH  = N_SW + N_BTN;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Milliseconds to clock cycles, never less than one cycle.
    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        int unsigned c;
        c = (freq / 1000) * ms;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/arty_s7_input_cond_if.sv
// Raw pad inputs and conditioned outputs of the board input stage.
interface arty_s7_input_cond_if;

    logic [arty_s7_pkg::N_SW-1:0]  sw_raw;
    logic [arty_s7_pkg::N_BTN-1:0] btn_raw;
    logic [arty_s7_pkg::N_SW-1:0]  sw_db;
    logic [arty_s7_pkg::N_BTN-1:0] btn_db;
    logic [arty_s7_pkg::N_BTN-1:0] btn_rise;
    logic [arty_s7_pkg::N_BTN-1:0] btn_fall;
    logic [arty_s7_pkg::N_BTN-1:0] btn_long;

    modport master (
        output sw_raw, btn_raw,
        input  sw_db, btn_db, btn_rise, btn_fall, btn_long
    );

    modport slave (
        input  sw_raw, btn_raw,
        output sw_db, btn_db, btn_rise, btn_fall, btn_long
    );

endinterface

// File: rtl/arty_s7_debounce_ch.sv
// One input channel: N-flop synchronizer, debounce counter, stable level and edge pulses.
// SYNC_STAGES must be at least 2.
module arty_s7_debounce_ch
    import arty_s7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s_c;
    logic                   differ_c;
    logic                   done_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s_c      = sync_q[SYNC_STAGES-1];
    assign differ_c = s_c ^ level;
    assign done_c   = differ_c && (cnt_q == CNT_LAST);

    // Any sample matching the stable level discards the partial count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= done_c &  s_c;
            fall <= done_c & ~s_c;
            if (!differ_c || done_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_c) begin
                level <= s_c;
            end
        end
    end

endmodule

// File: rtl/arty_s7_input_cond.sv
// Board input conditioning: synchronize and debounce 4 switches and 4 buttons.
// Define ARTY_S7_INPUT_COND_LONGPRESS_EN to generate the button long-press detectors.
module arty_s7_input_cond
    import arty_s7_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 12000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    arty_s7_input_cond_if.slave  bus
);

    localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);

    logic [N_CH-1:0]  ch_raw;
    logic [N_CH-1:0]  ch_level;
    logic [N_CH-1:0]  ch_rise;
    logic [N_CH-1:0]  ch_fall;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_SW-1:0]  sw_fall_unused;
    logic [N_BTN-1:0] btn_level_c;

    // Channels 0..N_SW-1 are switches, the rest are buttons.
    assign ch_raw = {bus.btn_raw, bus.sw_raw};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        arty_s7_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst),
            .raw   (ch_raw[g]),
            .level (ch_level[g]),
            .rise  (ch_rise[g]),
            .fall  (ch_fall[g])
        );
    end

    assign btn_level_c    = ch_level[N_CH-1:N_SW];
    assign bus.sw_db      = ch_level[N_SW-1:0];
    assign bus.btn_db     = btn_level_c;
    assign bus.btn_rise   = ch_rise[N_CH-1:N_SW];
    assign bus.btn_fall   = ch_fall[N_CH-1:N_SW];
    assign sw_rise_unused = ch_rise[N_SW-1:0];
    assign sw_fall_unused = ch_fall[N_SW-1:0];

`ifdef ARTY_S7_INPUT_COND_LONGPRESS_EN
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int unsigned LW          = clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0]    hold_q [N_BTN];
    logic [N_BTN-1:0] long_q;

    // Saturating hold counters; the pulse fires only on the step into HOLD_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                long_q[i] <= btn_level_c[i] && (hold_q[i] == HOLD_LAST);
                if (!btn_level_c[i]) begin
                    hold_q[i] <= '0;
                end else if (hold_q[i] != HOLD_MAX) begin
                    hold_q[i] <= hold_q[i] + LW'(1);
                end
            end
        end
    end

    assign bus.btn_long = long_q;
`else
    localparam int unsigned long_ms_unused = LONG_MS;

    assign bus.btn_long = '0;
`endif

endmodule
